// File: rtl/stream_mux_pkg.sv
// Shared constants and the mode encoding for the N-to-1 stream multiplexer.
package stream_mux_pkg;

  localparam int DEF_W = 4;
  localparam int DEF_N = 4;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr (mod N);
// ptr moves past the winner whenever the caller signals a completed transfer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;

  // N is a power of two, so PW-bit addition wraps modulo N for free.
  always_comb begin
    grant = '0;
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int o = 0; o < N; o++) begin
      cand = ptr + PW'(o);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) begin
      grant = N'(1) << win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= win + PW'(1);
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream mux with a one-word output register.
// Round-robin arbitration is built only when STREAM_MUX_RR_EN is defined.
//
// Handshake: a word moves on any rising edge where valid & ready are both high;
// valid never waits on ready, and a stalled output (out_valid & ~out_ready) is
// held stable, including out_data and out_chan.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N-1:0][W-1:0]  in_data,
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_chan
);

  localparam int PW = $clog2(N);

  logic [N-1:0]  sel_grant;
  logic [N-1:0]  grant;
  logic [PW-1:0] gidx;
  logic          space;
  logic          in_xfer;
  logic          out_xfer;

  assign sel_grant = N'(1) << sel;

`ifdef STREAM_MUX_RR_EN
  logic [N-1:0] rr_req;
  logic [N-1:0] rr_grant;

  // In explicit mode only the selected channel requests, so the pointer still
  // advances past whichever channel actually transferred.
  assign rr_req = (mode == MODE_RR) ? in_valid : (in_valid & sel_grant);
  assign grant  = (mode == MODE_RR) ? rr_grant : sel_grant;

  rr_arbiter #(.N(N)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rr_req),
    .advance (in_xfer),
    .grant   (rr_grant)
  );
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign grant       = sel_grant;
`endif

  assign space    = ~out_valid | out_ready;
  assign in_ready = grant & {N{space}};
  assign in_xfer  = |(in_valid & in_ready);
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx = gidx | PW'(i);
      end
    end
  end

  // Only the granted lane is ever read, so unknowns elsewhere cannot leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx];
      out_chan  <= gidx;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n (N=4, W=4): directed cases plus random
// traffic against a cycle-level reference model and an output-order scoreboard.
module tb_stream_mux_n;

  localparam int W = 4;
  localparam int N = 4;
`ifdef STREAM_MUX_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [N-1:0][W-1:0] in_data;
  logic [1:0]          sel;
  logic                mode;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [1:0]          out_chan;

  always #5 clk = ~clk;

  stream_mux_n #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];
  bit         m_ov;
  logic [3:0] m_od;
  logic [1:0] m_oc;
  int         m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant as the rules define it: sel decode, or first valid channel from the pointer.
  function automatic logic [3:0] m_grant();
    int c;
    if (RR_BUILD && mode) begin
      for (int o = 0; o < N; o++) begin
        c = (m_ptr + o) % N;
        if (in_valid[c]) return 4'(1 << c);
      end
      return 4'b0000;
    end
    return 4'(1 << sel);
  endfunction

  task automatic step();
    logic [3:0] g;
    logic [3:0] rdy;
    logic [5:0] e;
    int         k;
    #1;
    g   = m_grant();
    rdy = g & {4{!m_ov || out_ready}};
    check("in_ready", 32'(in_ready), 32'(rdy));
    if (out_valid && out_ready) begin
      check("sb_word_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_word", 32'({out_chan, out_data}), 32'(e));
      end
    end
    @(posedge clk);
    if (|(in_valid & rdy)) begin
      k = 0;
      for (int i = 0; i < N; i++) if (g[i]) k = i;
      exp_q.push_back({2'(k), in_data[k]});
      m_ov  = 1'b1;
      m_od  = in_data[k];
      m_oc  = 2'(k);
      m_ptr = (k + 1) % N;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("out_chan", 32'(out_chan), 32'(m_oc));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_chan", 32'(out_chan), 32'(0));
    m_ov  = 1'b0;
    m_od  = '0;
    m_oc  = '0;
    m_ptr = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] sweep_exp[4] = '{4'ha, 4'hb, 4'hc, 4'hd};
  logic [1:0] rr_seq_all[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] rr_seq_13[4]  = '{2'd1, 2'd3, 2'd1, 2'd3};

  initial begin
    in_valid  = '0;
    in_data   = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    #2;
    do_reset();

    // Reset release: idle output, ready mirrors the sel decode.
    #1;
    check("idle_in_ready", 32'(in_ready), 32'(4'b0001));
    step();

    // Explicit sweep.
    mode      = 1'b0;
    in_data   = {4'hd, 4'hc, 4'hb, 4'ha};
    in_valid  = 4'hf;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      check("sweep_data", 32'(out_data), 32'(sweep_exp[s]));
      check("sweep_chan", 32'(out_chan), 32'(s));
    end
    in_valid = '0;
    step();

    // Back-pressure on a held 'h5, then back-to-back release.
    sel       = 2'd0;
    in_data   = {4'h0, 4'h0, 4'h0, 4'h5};
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    step();
    in_data[0] = 4'h6;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_data", 32'(out_data), 32'(4'h5));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    step();
    check("bp_next_data", 32'(out_data), 32'(4'h6));
    check("bp_next_valid", 32'(out_valid), 32'(1));
    in_valid = '0;
    step();

    // Unknowns on non-granted lanes stay out of the output.
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = {4'hx, 4'h9, 4'hx, 4'hx};
    step();
    check("x_block_data", 32'(out_data), 32'(4'h9));
    check("x_block_known", 32'($isunknown(out_data)), 32'(0));
    in_valid = '0;
    in_data  = '0;
    step();

`ifdef STREAM_MUX_RR_EN
    do_reset();
    mode      = 1'b1;
    in_data   = {4'h3, 4'h2, 4'h1, 4'h0};
    in_valid  = 4'hf;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("rr_all_chan", 32'(out_chan), 32'(rr_seq_all[c]));
    end
    in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rr_13_chan", 32'(out_chan), 32'(rr_seq_13[c]));
    end
    in_valid = '0;
    step();
`else
    do_reset();
    mode      = 1'b1;
    sel       = 2'd2;
    in_data   = {4'h7, 4'h8, 4'h9, 4'ha};
    in_valid  = 4'hf;
    out_ready = 1'b1;
    #1;
    check("norr_in_ready", 32'(in_ready), 32'(4'b0100));
    for (int c = 0; c < 4; c++) begin
      step();
      check("norr_chan", 32'(out_chan), 32'(2));
    end
    in_valid = '0;
    step();
`endif

    // Reset while a word is stalled: it is discarded, pointer returns to 0.
    mode      = RR_BUILD;
    sel       = 2'd1;
    in_data   = {4'h4, 4'h3, 4'h2, 4'h1};
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    step();
    do_reset();
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    check("rst_no_xfer", 32'(out_valid), 32'(0));
    in_valid = 4'hf;
    sel      = 2'd0;
    step();
    check("rst_ptr_chan", 32'(out_chan), 32'(0));
    in_valid = '0;
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 16'($urandom);
      sel       = 2'($urandom_range(0, 3));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
